// File: rtl/pc_step_if.sv
// Fetch-stage PC control bus: redirect/trap/stall requests in, fetch address and fault status out.
interface pc_step_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            is_compressed;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            trap_valid;
    logic [XLEN-1:0] trap_vector;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next_seq;
    logic            fetch_valid;
    logic            misaligned_fault;
    logic [XLEN-1:0] fault_addr;

    modport master (
        output stall, is_compressed, redirect_valid, redirect_target, trap_valid, trap_vector,
        input  pc, pc_next_seq, fetch_valid, misaligned_fault, fault_addr
    );

    modport slave (
        input  stall, is_compressed, redirect_valid, redirect_target, trap_valid, trap_vector,
        output pc, pc_next_seq, fetch_valid, misaligned_fault, fault_addr
    );
endinterface

// File: rtl/pc_step_unit.sv
// Fetch program counter: sequential step of 2/4 bytes, redirects, trap entry, stall hold,
// and misaligned-redirect detection with a fault state that only a trap can leave.
module pc_step_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter bit              ENABLE_C     = 1'b1
) (
    input logic       clk,
    input logic       rst,
    pc_step_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] STEP_2     = {{(XLEN-3){1'b0}}, 3'd2};
    localparam logic [XLEN-1:0] STEP_4     = {{(XLEN-3){1'b0}}, 3'd4};
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    // Alignment rule depends on whether 16-bit instructions exist.
    function automatic logic target_misaligned(input logic [1:0] low_bits);
        if (ENABLE_C) begin
            return low_bits[0];
        end else begin
            return (low_bits != 2'b00);
        end
    endfunction

    state_t          state_r;
    state_t          state_next_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_next_s;
    logic [XLEN-1:0] pc_seq_s;
    logic [XLEN-1:0] trap_aligned_s;
    logic            fetch_valid_r;
    logic            fault_r;
    logic            fault_set_s;
    logic [XLEN-1:0] fault_addr_r;

    // Sequential successor and force-aligned trap target.
    always_comb begin
        pc_seq_s       = pc_r + ((ENABLE_C && bus.is_compressed) ? STEP_2 : STEP_4);
        trap_aligned_s = bus.trap_vector & ALIGN_MASK;
    end

    // Next-state and next-PC selection; trap beats redirect beats stall beats sequential.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        fault_set_s  = 1'b0;
        case (state_r)
            ST_BOOT: begin
                state_next_s = ST_RUN;
            end
            ST_RUN: begin
                if (bus.trap_valid) begin
                    pc_next_s = trap_aligned_s;
                end else if (bus.redirect_valid) begin
                    if (target_misaligned(bus.redirect_target[1:0])) begin
                        fault_set_s  = 1'b1;
                        state_next_s = ST_FAULT;
                    end else begin
                        pc_next_s = bus.redirect_target;
                    end
                end else if (bus.stall) begin
                    pc_next_s = pc_r;
                end else begin
                    pc_next_s = pc_seq_s;
                end
            end
            ST_FAULT: begin
                if (bus.trap_valid) begin
                    pc_next_s    = trap_aligned_s;
                    state_next_s = ST_RUN;
                end else begin
                    pc_next_s = pc_r;
                end
            end
            default: begin
                state_next_s = ST_BOOT;
                pc_next_s    = RESET_VECTOR;
            end
        endcase
    end

    // State, PC and status registers; fault_addr only moves on a new misaligned redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_BOOT;
            pc_r          <= RESET_VECTOR;
            fetch_valid_r <= 1'b0;
            fault_r       <= 1'b0;
            fault_addr_r  <= '0;
        end else begin
            state_r       <= state_next_s;
            pc_r          <= pc_next_s;
            fetch_valid_r <= (state_next_s == ST_RUN);
            fault_r       <= fault_set_s;
            if (fault_set_s) begin
                fault_addr_r <= bus.redirect_target;
            end
        end
    end

    assign bus.pc               = pc_r;
    assign bus.pc_next_seq      = pc_seq_s;
    assign bus.fetch_valid      = fetch_valid_r;
    assign bus.misaligned_fault = fault_r;
    assign bus.fault_addr       = fault_addr_r;
endmodule

// File: tb/tb_pc_step_unit.sv
// Directed bench for pc_step_unit: one compressed-ISA instance and one 4-byte-only instance.
module tb_pc_step_unit;
    logic clk;
    logic rst_c;
    logic rst_n4;
    int   vectors;
    int   miscompares;

    pc_step_if #(.XLEN(32)) bus_c ();
    pc_step_if #(.XLEN(32)) bus_n4 ();

    pc_step_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0100), .ENABLE_C(1'b1)) dut_c (
        .clk (clk),
        .rst (rst_c),
        .bus (bus_c)
    );

    pc_step_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .ENABLE_C(1'b0)) dut_n4 (
        .clk (clk),
        .rst (rst_n4),
        .bus (bus_n4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_c(input string tag, input logic [31:0] pc, input logic fv, input logic mf,
                         input logic [31:0] fa);
        check({tag, ".pc"}, 64'(bus_c.pc), 64'(pc));
        check({tag, ".fetch_valid"}, 64'(bus_c.fetch_valid), 64'(fv));
        check({tag, ".misaligned_fault"}, 64'(bus_c.misaligned_fault), 64'(mf));
        check({tag, ".fault_addr"}, 64'(bus_c.fault_addr), 64'(fa));
    endtask

    task automatic chk_n4(input string tag, input logic [31:0] pc, input logic fv, input logic mf,
                          input logic [31:0] fa);
        check({tag, ".pc"}, 64'(bus_n4.pc), 64'(pc));
        check({tag, ".fetch_valid"}, 64'(bus_n4.fetch_valid), 64'(fv));
        check({tag, ".misaligned_fault"}, 64'(bus_n4.misaligned_fault), 64'(mf));
        check({tag, ".fault_addr"}, 64'(bus_n4.fault_addr), 64'(fa));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_c       = 1'b1;
        rst_n4      = 1'b1;
        bus_c.stall = 1'b0;  bus_c.is_compressed = 1'b0;  bus_c.redirect_valid = 1'b0;
        bus_c.redirect_target = 32'h0;  bus_c.trap_valid = 1'b0;  bus_c.trap_vector = 32'h0;
        bus_n4.stall = 1'b0; bus_n4.is_compressed = 1'b0; bus_n4.redirect_valid = 1'b0;
        bus_n4.redirect_target = 32'h0; bus_n4.trap_valid = 1'b0; bus_n4.trap_vector = 32'h0;

        // Reset and boot
        step();
        chk_c("reset", 32'h100, 1'b0, 1'b0, 32'h0);
        rst_c = 1'b0;
        step();
        chk_c("boot_to_run", 32'h100, 1'b1, 1'b0, 32'h0);
        check("seq_next_100", 64'(bus_c.pc_next_seq), 64'h104);
        step();
        chk_c("seq_104", 32'h104, 1'b1, 1'b0, 32'h0);
        step();
        chk_c("seq_108", 32'h108, 1'b1, 1'b0, 32'h0);
        bus_c.is_compressed = 1'b1;
        #1;
        check("next_seq_compressed", 64'(bus_c.pc_next_seq), 64'h10A);
        step();
        chk_c("seq_10a", 32'h10A, 1'b1, 1'b0, 32'h0);
        bus_c.is_compressed = 1'b0;

        // Redirect, stall hold, redirect overriding stall
        bus_c.redirect_valid = 1'b1; bus_c.redirect_target = 32'h200;
        step();
        chk_c("redirect_200", 32'h200, 1'b1, 1'b0, 32'h0);
        bus_c.redirect_valid = 1'b0; bus_c.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", 64'(bus_c.pc), 64'h200);
        end
        bus_c.redirect_valid = 1'b1; bus_c.redirect_target = 32'h400;
        step();
        chk_c("redirect_over_stall", 32'h400, 1'b1, 1'b0, 32'h0);
        bus_c.stall = 1'b0;

        // Misaligned redirect, fault hold, trap recovery
        bus_c.redirect_target = 32'h301;
        step();
        chk_c("misaligned_pulse", 32'h400, 1'b0, 1'b1, 32'h301);
        bus_c.redirect_target = 32'h500; bus_c.stall = 1'b1;
        step();
        chk_c("fault_hold", 32'h400, 1'b0, 1'b0, 32'h301);
        bus_c.redirect_valid = 1'b0; bus_c.stall = 1'b0;
        bus_c.trap_valid = 1'b1; bus_c.trap_vector = 32'h803;
        step();
        chk_c("trap_exit_fault", 32'h800, 1'b1, 1'b0, 32'h301);
        bus_c.trap_valid = 1'b0;
        step();
        chk_c("seq_after_trap", 32'h804, 1'b1, 1'b0, 32'h301);
        bus_c.redirect_valid = 1'b1; bus_c.redirect_target = 32'h302;
        step();
        chk_c("halfword_target_ok", 32'h302, 1'b1, 1'b0, 32'h301);

        // Address wrap
        bus_c.redirect_target = 32'hFFFF_FFFC;
        step();
        check("wrap_pc", 64'(bus_c.pc), 64'hFFFF_FFFC);
        check("wrap_next_seq", 64'(bus_c.pc_next_seq), 64'h0);
        bus_c.redirect_valid = 1'b0;
        step();
        chk_c("wrap_to_zero", 32'h0, 1'b1, 1'b0, 32'h301);

        // Trap beats misaligned redirect
        bus_c.trap_valid = 1'b1; bus_c.trap_vector = 32'h904;
        bus_c.redirect_valid = 1'b1; bus_c.redirect_target = 32'h123;
        step();
        chk_c("trap_beats_misaligned", 32'h904, 1'b1, 1'b0, 32'h301);

        // Reset during trap+redirect collision
        rst_c = 1'b1;
        step();
        chk_c("rst_over_collision", 32'h100, 1'b0, 1'b0, 32'h0);
        rst_c = 1'b0;
        bus_c.redirect_valid = 1'b0;
        bus_c.trap_vector = 32'hA00;
        step();
        chk_c("trap_in_boot_ignored", 32'h100, 1'b1, 1'b0, 32'h0);
        bus_c.trap_valid = 1'b0;

        // Reset while in FAULT
        bus_c.redirect_valid = 1'b1; bus_c.redirect_target = 32'h555;
        step();
        chk_c("fault_before_rst", 32'h100, 1'b0, 1'b1, 32'h555);
        bus_c.redirect_valid = 1'b0; rst_c = 1'b1;
        step();
        chk_c("rst_in_fault", 32'h100, 1'b0, 1'b0, 32'h0);
        rst_c = 1'b0;

        // Word-aligned-only instance
        rst_n4 = 1'b0;
        step();
        chk_n4("n4_boot_to_run", 32'h0, 1'b1, 1'b0, 32'h0);
        bus_n4.redirect_valid = 1'b1; bus_n4.redirect_target = 32'h302;
        step();
        chk_n4("n4_misaligned", 32'h0, 1'b0, 1'b1, 32'h302);
        bus_n4.redirect_valid = 1'b0;
        bus_n4.trap_valid = 1'b1; bus_n4.trap_vector = 32'h12;
        step();
        chk_n4("n4_trap", 32'h10, 1'b1, 1'b0, 32'h302);
        bus_n4.trap_valid = 1'b0;
        bus_n4.redirect_valid = 1'b1; bus_n4.redirect_target = 32'h304;
        step();
        chk_n4("n4_redirect_304", 32'h304, 1'b1, 1'b0, 32'h302);
        bus_n4.redirect_valid = 1'b0; bus_n4.is_compressed = 1'b1;
        #1;
        check("n4_next_seq_step4", 64'(bus_n4.pc_next_seq), 64'h308);
        step();
        chk_n4("n4_seq_308", 32'h308, 1'b1, 1'b0, 32'h302);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_step_unit.md
# pc_step_unit

Parametrised program-counter register with next-PC selection for the fetch stage of the HolySoC RISC-V core. It holds the current fetch address and advances it by 2 or 4 bytes, depending on whether the current instruction is compressed. It also accepts branch/jump redirects and trap entries, honours pipeline stalls, and detects misaligned redirect targets, which it reports and holds until the trap handler is entered.

## Interface
- XLEN, 32, address width in bits (32 or 64).
- RESET_VECTOR, 32'h0000_0000 (XLEN wide), PC value loaded on reset.
- ENABLE_C, 1, 1 = compressed ISA allowed (2-byte alignment, step 2 or 4); 0 = 4-byte alignment, step always 4.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- stall  in  1  hold PC (fetch stage back-pressure).
- is_compressed  in  1  current instruction at pc is 16-bit; ignored when ENABLE_C=0.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  XLEN  redirect destination.
- trap_valid  in  1  trap/interrupt entry this cycle.
- trap_vector  in  XLEN  trap handler address (mtvec base).
- pc  out  XLEN  current fetch address (registered).
- pc_next_seq  out  XLEN  combinational pc + step (link value for JAL/JALR).
- fetch_valid  out  1  pc is a valid fetch address this cycle.
- misaligned_fault  out  1  one-cycle pulse: redirect target misaligned.
- fault_addr  out  XLEN  latched offending target.

## Operation
- step = 2 if ENABLE_C=1 and is_compressed=1, else 4. pc_next_seq = pc + step, modulo 2^XLEN (wrap, no flag).
- Misaligned target: redirect_target[0]=1 when ENABLE_C=1; redirect_target[1:0]!=0 when ENABLE_C=0.
- trap_vector is force-aligned: bits [1:0] cleared before load; never faults.
- States: BOOT, RUN, FAULT.
  - BOOT: entered on rst; pc=RESET_VECTOR, fetch_valid=0. Next edge without rst -> RUN, pc unchanged.
  - RUN: fetch_valid=1. Per-edge priority: trap_valid > redirect_valid > stall > sequential.
    - trap: pc <= aligned trap_vector, stay RUN.
    - redirect aligned: pc <= redirect_target (overrides stall).
    - redirect misaligned: pc unchanged, fault_addr <= redirect_target, misaligned_fault=1 next cycle, -> FAULT.
    - stall only: pc unchanged.
    - otherwise: pc <= pc_next_seq.
  - FAULT: fetch_valid=0, pc frozen, redirect_valid and stall ignored. trap_valid -> pc <= aligned trap_vector, -> RUN.
- trap_valid in BOOT is ignored (BOOT always lasts exactly one cycle).
- fault_addr is held until the next misaligned redirect or rst.

## Timing
- Reset values: pc=RESET_VECTOR, fetch_valid=0, misaligned_fault=0, fault_addr=0, state=BOOT.
- rst overrides every input on the same edge, including mid-FAULT and mid-stall.
- Latency: redirect/trap sampled at edge N is visible on pc after edge N; first redirected fetch is in cycle N+1.
- misaligned_fault is high for exactly the one cycle following the detecting edge; fetch_valid is low from that cycle onward.
- pc_next_seq is combinational from pc and is_compressed; no registered path.
- Simultaneous trap_valid and misaligned redirect: trap wins, no fault, fault_addr unchanged.
- Simultaneous redirect and stall: redirect wins.

## Test plan
- Reset then run, ENABLE_C=1, RESET_VECTOR=0x100, is_compressed=0 -> fetch_valid=0 one cycle at 0x100, then pc 0x100, 0x104, 0x108; with is_compressed=1 from 0x108 -> 0x10A.
- Stall 3 cycles at pc=0x200 -> pc holds 0x200; redirect_valid=1 to 0x400 while stalled -> pc=0x400 next cycle.
- ENABLE_C=1, redirect to 0x301 -> misaligned_fault pulses 1 cycle, fault_addr=0x301, pc frozen, fetch_valid=0; trap_valid with vector 0x803 -> pc=0x800, RUN.
- ENABLE_C=0, redirect to 0x302 -> fault; redirect to 0x304 -> pc=0x304; is_compressed=1 still gives step 4.
- pc=0xFFFF_FFFC, sequential -> pc=0x0000_0000, no fault.
- rst asserted in FAULT and during trap+redirect collision -> all outputs at reset values next cycle; trap+misaligned redirect without rst -> pc=trap vector, misaligned_fault stays 0.
